// File: rtl/aq_djpeg_byte_window_pkg.sv
// Shared constants and helpers for the JPEG ingress byte window and its unstuffing stage.
package aq_djpeg_byte_window_pkg;

  localparam logic [7:0] JPEG_BYTE_FF = 8'hFF;
  localparam logic [7:0] JPEG_STUFF   = 8'h00;
  localparam int         WIN_BYTES    = 4;
  localparam int         BUF_BYTES    = 8;

  // UseWord has priority when both strobes are raised.
  function automatic logic [1:0] consume_amt(input logic use_byte, input logic use_word);
    if (use_word) return 2'd2;
    else if (use_byte) return 2'd1;
    else return 2'd0;
  endfunction

endpackage

// File: rtl/aq_djpeg_byte_window_unstuff.sv
// Combinational 0xFF00 unstuffer for one 32-bit word: drops a 0x00 that follows a raw 0xFF and
// compacts the surviving bytes MSB-first.
module aq_djpeg_unstuff
  import aq_djpeg_byte_window_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic        i_en,
  input  logic        i_prev_ff,
  output logic [31:0] o_kept,
  output logic [2:0]  o_count,
  output logic        o_last_ff
);

  logic [7:0] w_byte;
  logic       w_prev;

  always_comb begin
    o_kept  = '0;
    o_count = '0;
    w_byte  = '0;
    w_prev  = i_prev_ff;
    for (int i = 0; i < 4; i++) begin
      w_byte = i_word[31-8*i -: 8];
      // The "previous byte" is always the raw one, so FF 00 00 keeps the second 00.
      if (!(i_en && (w_byte == JPEG_STUFF) && w_prev)) begin
        o_kept  = o_kept | ({w_byte, 24'h0} >> {o_count, 3'b000});
        o_count = o_count + 3'd1;
      end
      w_prev = (w_byte == JPEG_BYTE_FF);
    end
    o_last_ff = w_prev;
  end

endmodule

// File: rtl/aq_djpeg_byte_window.sv
// Ingress byte window: buffers up to 8 bytes from 32-bit words and exposes a 4-byte look-ahead
// window (oldest byte in [31:24]) that the marker FSM retires 1 or 2 bytes at a time.
module aq_djpeg_byte_window
  import aq_djpeg_byte_window_pkg::*;
#(
  parameter int         STUFF_EN = 1,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_InValid,
  input  logic [31:0] i_InData,
  input  logic        i_InLast,
  output logic        o_InReady,
  input  logic        i_StuffRemove,
  output logic        o_DataOutEnable,
  output logic [31:0] o_DataOut,
  output logic        o_DataOutEnd,
  input  logic        i_UseByte,
  input  logic        i_UseWord,
  output logic [3:0]  o_Level
);

  logic [BUF_BYTES*8-1:0] r_buf;
  logic [3:0]             r_count;
  logic                   r_end_seen;
  logic                   r_prev_ff;

  logic [31:0]            w_kept;
  logic [2:0]             w_kept_n;
  logic                   w_last_ff;
  logic                   w_unstuff_en;
  logic [3:0]             w_c;
  logic [3:0]             w_rem;
  logic [3:0]             w_base;
  logic                   w_accept;
  logic                   w_restart;
  logic [31:0]            w_kmask;
  logic [63:0]            w_mask;
  logic [63:0]            w_app;
  logic [63:0]            w_shifted;
  logic [63:0]            w_buf_next;
  logic [3:0]             w_count_next;

  assign w_unstuff_en = (STUFF_EN != 0) && i_StuffRemove;

  aq_djpeg_unstuff u_unstuff (
    .i_word    (i_InData),
    .i_en      (w_unstuff_en),
    .i_prev_ff (r_prev_ff),
    .o_kept    (w_kept),
    .o_count   (w_kept_n),
    .o_last_ff (w_last_ff)
  );

  assign o_InReady       = (r_count <= 4'(WIN_BYTES)) && !r_end_seen;
  assign o_DataOutEnable = (r_count >= 4'(WIN_BYTES)) || (r_end_seen && (r_count != 4'd0));
  assign o_DataOutEnd    = r_end_seen && (r_count == 4'd0);
  assign o_Level         = r_count;

  assign o_DataOut[31:24] = (r_count > 4'd0) ? r_buf[63:56] : PAD_BYTE;
  assign o_DataOut[23:16] = (r_count > 4'd1) ? r_buf[55:48] : PAD_BYTE;
  assign o_DataOut[15:8]  = (r_count > 4'd2) ? r_buf[47:40] : PAD_BYTE;
  assign o_DataOut[7:0]   = (r_count > 4'd3) ? r_buf[39:32] : PAD_BYTE;

  // Draining past the end removes only what is held, so Count cannot wrap.
  assign w_c       = o_DataOutEnable ? {2'b00, consume_amt(i_UseByte, i_UseWord)} : 4'd0;
  assign w_rem     = (w_c > r_count) ? r_count : w_c;
  assign w_base    = r_count - w_rem;
  assign w_accept  = i_InValid && o_InReady;
  assign w_restart = o_DataOutEnd && i_InValid;

  // Shift out first, then splice the kept bytes in at the post-shift fill level.
  assign w_shifted    = r_buf << {w_rem, 3'b000};
  assign w_kmask      = ~(32'hFFFF_FFFF >> {w_kept_n, 3'b000});
  assign w_mask       = {w_kmask, 32'h0} >> {w_base, 3'b000};
  assign w_app        = {w_kept, 32'h0} >> {w_base, 3'b000};
  assign w_buf_next   = w_accept ? ((w_shifted & ~w_mask) | (w_app & w_mask)) : w_shifted;
  assign w_count_next = w_base + (w_accept ? {1'b0, w_kept_n} : 4'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf      <= '0;
      r_count    <= '0;
      r_end_seen <= 1'b0;
      r_prev_ff  <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_count <= w_count_next;
      if (w_restart) begin
        r_end_seen <= 1'b0;
        r_prev_ff  <= 1'b0;
      end else if (w_accept) begin
        r_prev_ff <= w_last_ff;
        if (i_InLast) r_end_seen <= 1'b1;
      end
    end
  end

  a_one_strobe: assert property (@(posedge i_clk) disable iff (i_rst) !(i_UseByte && i_UseWord));

endmodule
